// File: rtl/register_if.sv
// rtl/register_if.sv - load-enable register data bus with master/slave modports
interface register_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    modport master (
        output en,
        output d,
        input  q
    );

    modport slave (
        input  en,
        input  d,
        output q
    );
endinterface

// File: rtl/register.sv
// rtl/register.sv - WIDTH-bit load-enable register with synchronous active-low reset
module register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // Reset wins over en; q comes straight from the flops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: tb/tb_register.sv
// tb/tb_register.sv - randomized self-checking bench for register against a behavioural model
module tb_register;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   cov_rst;
    int   cov_en;
    int   cov_d0;
    int   cov_d1;
    bit   started;
    logic [WIDTH-1:0] exp_q;

    register_if #(.WIDTH(WIDTH)) bus ();

    register #(
        .WIDTH       (WIDTH),
        .RESET_VALUE ('0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (bus.en),
        .d   (bus.d),
        .q   (bus.q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, confirm q ignores mid-cycle input changes, then check after the edge.
    task automatic step(input string tag, input logic r, input logic e, input logic [WIDTH-1:0] dv);
        @(negedge clk);
        rst    = r;
        bus.en = e;
        bus.d  = dv;
        #1;
        if (started) check("stable_between_edges", bus.q, exp_q);
        @(posedge clk);
        if (!r)     exp_q = '0;
        else if (e) exp_q = dv;
        started = 1'b1;
        if (!r)         cov_rst++;
        if (e)          cov_en++;
        if (dv == '0)   cov_d0++;
        if (dv == '1)   cov_d1++;
        #1;
        check(tag, bus.q, exp_q);
    endtask

    initial begin
        logic [WIDTH-1:0] prev_q;
        logic [WIDTH-1:0] rd;
        logic             re;
        errors  = 0;
        checks  = 0;
        cov_rst = 0;
        cov_en  = 0;
        cov_d0  = 0;
        cov_d1  = 0;
        started = 1'b0;
        exp_q   = '0;
        rst     = 1'b0;
        bus.en  = 1'b0;
        bus.d   = '0;

        // Held reset with random en/d
        for (int i = 0; i < 5; i++) begin
            step("reset_hold", 1'b0, 1'($urandom), $urandom);
            check("reset_hold_const", bus.q, 32'h0000_0000);
        end

        // Resume immediately, all-zeros then all-ones
        step("load_zero", 1'b1, 1'b1, 32'h0000_0000);
        check("load_zero_const", bus.q, 32'h0000_0000);
        step("load_ones", 1'b1, 1'b1, 32'hFFFF_FFFF);
        check("load_ones_const", bus.q, 32'hFFFF_FFFF);

        // Load then hold for 3 cycles while d changes
        step("load_a5", 1'b1, 1'b1, 32'hA5A5_A5A5);
        for (int i = 0; i < 3; i++) begin
            step("hold_a5", 1'b1, 1'b0, $urandom);
            check("hold_a5_const", bus.q, 32'hA5A5_A5A5);
        end

        // Reset priority over en, then recovery on the next edge
        step("rst_over_en", 1'b0, 1'b1, 32'h1234_5678);
        check("rst_over_en_const", bus.q, 32'h0000_0000);
        step("rst_release", 1'b1, 1'b1, 32'h1234_5678);
        check("rst_release_const", bus.q, 32'h1234_5678);

        // Reset in the middle of a back-to-back load burst
        step("burst_a", 1'b1, 1'b1, 32'hDEAD_BEEF);
        step("burst_b", 1'b1, 1'b1, 32'hCAFE_F00D);
        step("burst_rst", 1'b0, 1'b1, 32'h0BAD_CAFE);
        check("burst_rst_const", bus.q, 32'h0000_0000);

        // en toggling every cycle
        for (int i = 0; i < 8; i++) begin
            step("en_toggle", 1'b1, 1'(i % 2 == 0), $urandom);
        end

        // Random en/d: loaded value is the previous cycle's d, otherwise unchanged
        for (int i = 0; i < 10000; i++) begin
            case ($urandom_range(0, 15))
                0:       rd = '0;
                1:       rd = '1;
                default: rd = $urandom;
            endcase
            re     = 1'($urandom);
            prev_q = bus.q;
            step("random", 1'b1, re, rd);
            check("random_rule", bus.q, re ? rd : prev_q);
        end

        check("cov_rst_seen", 32'(cov_rst != 0), 32'd1);
        check("cov_en_seen",  32'(cov_en  != 0), 32'd1);
        check("cov_d0_seen",  32'(cov_d0  != 0), 32'd1);
        check("cov_d1_seen",  32'(cov_d1  != 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
